// File: rtl/batalha_pkg.sv
// Shared types and sizing helpers for the naval-battle game controller.
// Imported by the turn sequencer and the target selector.
package batalha_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL_X,
        SEL_Y,
        ISSUE,
        WAIT_RES,
        OVER
    } state_t;

    localparam int DEF_N_PLAYERS  = 2;
    localparam int DEF_BOARD_W    = 8;
    localparam int DEF_BOARD_H    = 8;
    localparam int DEF_SHIP_CELLS = 9;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    // Index width for n values, never below one bit.
    function automatic int w_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seletor_alvo.sv
// Finds the next alive player after cur_player, wrapping around,
// and flags when exactly one player is still alive.
module seletor_alvo
#(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  alive,
    input  logic [PW-1:0] cur_player,
    output logic [PW-1:0] next_player,
    output logic          only_one
);

    int d;
    int best;
    int cnt;

    // Smallest nonzero forward distance wins; count survivors.
    always_comb begin
        next_player = cur_player;
        best        = N;
        d           = 0;
        cnt         = 0;
        for (int j = 0; j < N; j++) begin
            d = (j - int'(cur_player) + N) % N;
            if (alive[j]) begin
                cnt++;
                if (d != 0 && d < best) begin
                    best        = d;
                    next_player = PW'(j);
                end
            end
        end
        only_one = (cnt == 1);
    end

endmodule

// File: rtl/jogo_multijogador.sv
// Game-execution controller: turn sequencing, shot entry, collider
// handshake, hit bookkeeping, elimination and winner declaration.
module jogo_multijogador
    import batalha_pkg::*;
#(
    parameter int N_PLAYERS  = DEF_N_PLAYERS,
    parameter int BOARD_W    = DEF_BOARD_W,
    parameter int BOARD_H    = DEF_BOARD_H,
    parameter int SHIP_CELLS = DEF_SHIP_CELLS,
    localparam int PW = w_of(N_PLAYERS),
    localparam int XW = w_of(BOARD_W),
    localparam int YW = w_of(BOARD_H),
    localparam int CW = w_of(SHIP_CELLS + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   enter,
    input  logic                   select,
    input  logic                   mode,
    input  logic [XW-1:0]          rnd_x,
    input  logic [YW-1:0]          rnd_y,
    output logic                   shot_valid,
    input  logic                   shot_ready,
    output logic [XW-1:0]          shot_x,
    output logic [YW-1:0]          shot_y,
    output logic [PW-1:0]          shot_target,
    input  logic                   res_valid,
    input  logic                   res_hit,
    input  logic                   res_repeat,
    output logic [PW-1:0]          cur_player,
    output logic [XW-1:0]          cursor_x,
    output logic [YW-1:0]          cursor_y,
    output logic [N_PLAYERS-1:0]   alive,
    output logic [N_PLAYERS*CW-1:0] hits_taken,
    output logic                   game_over,
    output logic [PW-1:0]          winner
);

    state_t state, state_d;
    logic   mode_q, mode_d;
    logic   sv_d;
    logic   go_d;
    logic   issue_go;
    logic   elim;
    logic   sel_one;

    logic [XW-1:0] sx_d, cx_d;
    logic [YW-1:0] sy_d, cy_d;
    logic [PW-1:0] st_d, cp_d, win_d, sel_next;
    logic [CW-1:0] hit_cnt;

    logic [N_PLAYERS-1:0] alive_d, alive_hit, alive_sel;
    logic [N_PLAYERS-1:0][CW-1:0] hits_q, hits_d;

    assign hits_taken = hits_q;

    // Only the eliminating hit needs the post-hit survivor view.
    seletor_alvo #(
        .N  (N_PLAYERS),
        .PW (PW)
    ) u_sel (
        .alive       (alive_sel),
        .cur_player  (cur_player),
        .next_player (sel_next),
        .only_one    (sel_one)
    );

    // Prospective counter and alive mask if the pending result is a hit.
    always_comb begin
        hit_cnt = hits_q[shot_target];
        if (hit_cnt != CW'(SHIP_CELLS)) begin
            hit_cnt = hit_cnt + 1'b1;
        end
        alive_hit = alive;
        if (hit_cnt == CW'(SHIP_CELLS)) begin
            alive_hit[shot_target] = 1'b0;
        end
        elim = (state == WAIT_RES) && res_valid
            && res_hit && !res_repeat;
        alive_sel = elim ? alive_hit : alive;
    end

    // Next-state and next-output logic; everything holds by default.
    always_comb begin
        state_d  = state;
        mode_d   = mode_q;
        sv_d     = shot_valid;
        sx_d     = shot_x;
        sy_d     = shot_y;
        st_d     = shot_target;
        cp_d     = cur_player;
        cx_d     = cursor_x;
        cy_d     = cursor_y;
        alive_d  = alive;
        hits_d   = hits_q;
        go_d     = game_over;
        win_d    = winner;
        issue_go = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d = SEL_X;
                    mode_d  = mode;
                    alive_d = '1;
                    hits_d  = '0;
                    cp_d    = '0;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            SEL_X: begin
                if (mode_q == MODE_AUTO) begin
                    if (int'(rnd_x) < BOARD_W
                        && int'(rnd_y) < BOARD_H) begin
                        sx_d     = rnd_x;
                        sy_d     = rnd_y;
                        issue_go = 1'b1;
                    end
                end else if (enter) begin
                    sx_d    = cursor_x;
                    state_d = SEL_Y;
                end else if (select) begin
                    cx_d = (cursor_x == XW'(BOARD_W - 1))
                        ? '0 : cursor_x + 1'b1;
                end
            end
            SEL_Y: begin
                if (enter) begin
                    sy_d     = cursor_y;
                    issue_go = 1'b1;
                end else if (select) begin
                    cy_d = (cursor_y == YW'(BOARD_H - 1))
                        ? '0 : cursor_y + 1'b1;
                end
            end
            ISSUE: begin
                if (shot_ready) begin
                    sv_d    = 1'b0;
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (res_valid) begin
                    if (res_repeat) begin
                        state_d = SEL_X;
                        mode_d  = mode;
                    end else if (res_hit) begin
                        hits_d[shot_target] = hit_cnt;
                        alive_d = alive_hit;
                        if (sel_one) begin
                            state_d = OVER;
                            go_d    = 1'b1;
                            win_d   = cur_player;
                        end else begin
                            state_d = SEL_X;
                            mode_d  = mode;
                        end
                    end else begin
                        cp_d    = sel_next;
                        state_d = SEL_X;
                        mode_d  = mode;
                    end
                end
            end
            OVER: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (issue_go) begin
            state_d = ISSUE;
            sv_d    = 1'b1;
            st_d    = sel_next;
        end
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            mode_q      <= MODE_MANUAL;
            shot_valid  <= 1'b0;
            shot_x      <= '0;
            shot_y      <= '0;
            shot_target <= '0;
            cur_player  <= '0;
            cursor_x    <= '0;
            cursor_y    <= '0;
            alive       <= '1;
            hits_q      <= '0;
            game_over   <= 1'b0;
            winner      <= '0;
        end else begin
            state       <= state_d;
            mode_q      <= mode_d;
            shot_valid  <= sv_d;
            shot_x      <= sx_d;
            shot_y      <= sy_d;
            shot_target <= st_d;
            cur_player  <= cp_d;
            cursor_x    <= cx_d;
            cursor_y    <= cy_d;
            alive       <= alive_d;
            hits_q      <= hits_d;
            game_over   <= go_d;
            winner      <= win_d;
        end
    end

endmodule

// File: tb/tb_jogo_multijogador.sv
// Bench for jogo_multijogador: 3 players, 8x6 board, 2-cell fleets.
// Expected shots are queued at entry and checked at the handshake.
module tb_jogo_multijogador;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       enter = 1'b0;
    logic       select = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] rnd_x = '0;
    logic [2:0] rnd_y = '0;
    logic       shot_valid;
    logic       shot_ready = 1'b0;
    logic [2:0] shot_x;
    logic [2:0] shot_y;
    logic [1:0] shot_target;
    logic       res_valid = 1'b0;
    logic       res_hit = 1'b0;
    logic       res_repeat = 1'b0;
    logic [1:0] cur_player;
    logic [2:0] cursor_x;
    logic [2:0] cursor_y;
    logic [2:0] alive;
    logic [5:0] hits_taken;
    logic       game_over;
    logic [1:0] winner;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    jogo_multijogador #(
        .N_PLAYERS  (3),
        .BOARD_W    (8),
        .BOARD_H    (6),
        .SHIP_CELLS (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .enter       (enter),
        .select      (select),
        .mode        (mode),
        .rnd_x       (rnd_x),
        .rnd_y       (rnd_y),
        .shot_valid  (shot_valid),
        .shot_ready  (shot_ready),
        .shot_x      (shot_x),
        .shot_y      (shot_y),
        .shot_target (shot_target),
        .res_valid   (res_valid),
        .res_hit     (res_hit),
        .res_repeat  (res_repeat),
        .cur_player  (cur_player),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .alive       (alive),
        .hits_taken  (hits_taken),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sel(input int n);
        for (int i = 0; i < n; i++) begin
            select = 1'b1;
            tick();
            select = 1'b0;
        end
    endtask

    task automatic pulse_enter();
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic handshake();
        int n;
        n = 0;
        while (!shot_valid && n < 20) begin
            tick();
            n++;
        end
        chk("valid_wait", shot_valid, 1);
        shot_ready = 1'b1;
        tick();
        shot_ready = 1'b0;
        chk("valid_drop", shot_valid, 0);
    endtask

    task automatic result(input logic h, input logic r);
        res_valid  = 1'b1;
        res_hit    = h;
        res_repeat = r;
        tick();
        res_valid  = 1'b0;
        res_hit    = 1'b0;
        res_repeat = 1'b0;
    endtask

    task automatic manual_shot(input logic [7:0] e);
        exp_q.push_back(e);
        pulse_enter();
        pulse_enter();
        handshake();
    endtask

    // Scoreboard side: compare every accepted shot with the queue.
    always @(negedge clk) begin
        if (reset && shot_valid && shot_ready) begin
            if (exp_q.size() == 0) begin
                chk("shot_unexpected", 1, 0);
            end else begin
                chk("shot", {shot_target, shot_x, shot_y},
                    exp_q.pop_front());
            end
        end
    end

    initial begin
        tick();
        tick();
        chk("rst_valid", shot_valid, 0);
        chk("rst_cp", cur_player, 0);
        chk("rst_alive", alive, 3'b111);
        chk("rst_hits", hits_taken, 0);
        chk("rst_over", game_over, 0);
        chk("rst_curs", {cursor_x, cursor_y}, 0);
        reset = 1'b1;

        start = 1'b1;
        tick();
        start = 1'b0;
        pulse_sel(3);
        chk("cur_x3", cursor_x, 3);
        pulse_enter();
        pulse_sel(5);
        chk("cur_y5", cursor_y, 5);
        exp_q.push_back({2'd1, 3'd3, 3'd5});
        pulse_enter();
        chk("issue_valid", shot_valid, 1);
        chk("issue_data", {shot_target, shot_x, shot_y},
            {2'd1, 3'd3, 3'd5});
        handshake();
        result(1'b0, 1'b0);
        chk("miss_cp", cur_player, 1);

        pulse_sel(9);
        chk("wrap_x", cursor_x, 4);
        enter  = 1'b1;
        select = 1'b1;
        tick();
        enter  = 1'b0;
        select = 1'b0;
        chk("prio_x", cursor_x, 4);
        exp_q.push_back({2'd2, 3'd4, 3'd5});
        pulse_enter();
        handshake();
        result(1'b1, 1'b1);
        chk("rep_cp", cur_player, 1);
        chk("rep_hits", hits_taken, 0);
        chk("rep_alive", alive, 3'b111);

        manual_shot({2'd2, 3'd4, 3'd5});
        result(1'b1, 1'b0);
        chk("hit1_hits", hits_taken, 6'b01_00_00);
        chk("hit1_cp", cur_player, 1);
        manual_shot({2'd2, 3'd4, 3'd5});
        result(1'b1, 1'b0);
        chk("hit2_hits", hits_taken, 6'b10_00_00);
        chk("elim_alive", alive, 3'b011);
        chk("elim_over", game_over, 0);
        manual_shot({2'd0, 3'd4, 3'd5});
        result(1'b0, 1'b0);
        chk("skip_cp", cur_player, 0);

        manual_shot({2'd1, 3'd4, 3'd5});
        result(1'b1, 1'b0);
        chk("p1_hits", hits_taken, 6'b10_01_00);
        manual_shot({2'd1, 3'd4, 3'd5});
        res_valid = 1'b1;
        res_hit   = 1'b1;
        chk("over_early", game_over, 0);
        tick();
        res_valid = 1'b0;
        res_hit   = 1'b0;
        chk("over", game_over, 1);
        chk("winner", winner, 0);
        chk("over_alive", alive, 3'b001);
        chk("over_hits", hits_taken, 6'b10_10_00);
        start = 1'b1;
        tick();
        start = 1'b0;
        result(1'b1, 1'b0);
        chk("over_hold", game_over, 1);
        chk("over_hold_hits", hits_taken, 6'b10_10_00);
        reset = 1'b0;
        #1;
        chk("arst_over", game_over, 0);
        chk("arst_alive", alive, 3'b111);
        chk("arst_hits", hits_taken, 0);
        chk("arst_cp", cur_player, 0);
        tick();
        reset = 1'b1;

        mode  = 1'b1;
        rnd_x = 3'd2;
        rnd_y = 3'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("auto_retry", shot_valid, 0);
        end
        rnd_y = 3'd4;
        exp_q.push_back({2'd1, 3'd2, 3'd4});
        tick();
        chk("auto_issue", shot_valid, 1);
        rnd_x = 3'd5;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", shot_valid, 1);
            chk("stall_data", {shot_target, shot_x, shot_y},
                {2'd1, 3'd2, 3'd4});
        end
        handshake();
        result(1'b0, 1'b0);
        chk("auto_cp", cur_player, 1);
        exp_q.push_back({2'd2, 3'd5, 3'd4});
        shot_ready = 1'b1;
        tick();
        chk("fast_valid", shot_valid, 1);
        tick();
        shot_ready = 1'b0;
        chk("fast_done", shot_valid, 0);
        result(1'b0, 1'b0);
        chk("auto_cp2", cur_player, 2);
        tick();
        chk("inflight", shot_valid, 1);
        chk("inflight_t", shot_target, 0);
        reset = 1'b0;
        #1;
        chk("abort_valid", shot_valid, 0);
        chk("abort_cp", cur_player, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
